// File: rtl/player2_ai_ctl_if.sv
// player2_ai_ctl_if: frame/ball/score inputs and paddle outputs of the player-2 AI.
interface player2_ai_ctl_if;
    logic        vsync_in;
    logic [11:0] xpos_ball;
    logic [11:0] ypos_ball;
    logic [3:0]  player_1_score;
    logic [3:0]  player_2_score;
    logic [11:0] xpos_out;
    logic [11:0] ypos_out;
    logic [1:0]  state_out;

    modport master (
        output vsync_in, xpos_ball, ypos_ball, player_1_score, player_2_score,
        input  xpos_out, ypos_out, state_out
    );

    modport slave (
        input  vsync_in, xpos_ball, ypos_ball, player_1_score, player_2_score,
        output xpos_out, ypos_out, state_out
    );
endinterface

// File: rtl/player2_ai_ctl.sv
// player2_ai_ctl: computer opponent; steps the player-2 paddle toward a ball-derived
// target once per frame, and snaps home then pauses after any goal.
module player2_ai_ctl #(
    parameter logic [11:0] MID_X       = 12'd512,
    parameter logic [11:0] X_MIN       = 12'd532,
    parameter logic [11:0] X_MAX       = 12'd980,
    parameter logic [11:0] Y_MIN       = 12'd40,
    parameter logic [11:0] Y_MAX       = 12'd728,
    parameter logic [11:0] HOME_X      = 12'd900,
    parameter logic [11:0] HOME_Y      = 12'd384,
    parameter int unsigned STEP        = 4,
    parameter int unsigned HOLD_FRAMES = 60
) (
    input  logic                   clk,
    input  logic                   rst_n,
    player2_ai_ctl_if.slave        bus
);
    typedef enum logic [1:0] {HOME_WAIT = 2'd0, GUARD = 2'd1, TRACK = 2'd2} state_t;

    localparam logic [11:0]        STEP_U    = 12'(STEP);
    localparam logic signed [12:0] STEP_S    = 13'(STEP);
    localparam logic [7:0]         HOLD_INIT = 8'(HOLD_FRAMES);

    state_t      state_q, state_d;
    logic [11:0] x_q, x_d, y_q, y_d;
    logic [7:0]  hold_q, hold_d;
    logic        vsync_prev_q;
    logic [3:0]  p1_prev_q, p2_prev_q;
    logic        tick, goal;
    state_t      sel;
    logic [11:0] tx, ty;

    function automatic logic [11:0] clamp(input logic [11:0] v, input logic [11:0] lo,
                                          input logic [11:0] hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    // Both p and t lie inside the clamp window, so a capped step never leaves it.
    function automatic logic [11:0] approach(input logic [11:0] p, input logic [11:0] t);
        logic signed [12:0] d;
        d = $signed({1'b0, t}) - $signed({1'b0, p});
        return (d > STEP_S) ? p + STEP_U : (d < -STEP_S) ? p - STEP_U : t;
    endfunction

    assign tick = bus.vsync_in & ~vsync_prev_q;
    assign goal = {bus.player_1_score, bus.player_2_score} != {p1_prev_q, p2_prev_q};
    assign sel  = (bus.xpos_ball >= MID_X) ? TRACK : GUARD;
    assign tx   = clamp((sel == TRACK) ? bus.xpos_ball : HOME_X, X_MIN, X_MAX);
    assign ty   = clamp(bus.ypos_ball, Y_MIN, Y_MAX);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        hold_d  = hold_q;
        if (goal) begin
            state_d = HOME_WAIT;
            x_d     = HOME_X;
            y_d     = HOME_Y;
            hold_d  = HOLD_INIT;
        end else if (tick) begin
            if (state_q == HOME_WAIT && hold_q != 8'd0) begin
                hold_d = hold_q - 8'd1;
            end else begin
                state_d = sel;
                x_d     = approach(x_q, tx);
                y_d     = approach(y_q, ty);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HOME_WAIT;
            x_q          <= HOME_X;
            y_q          <= HOME_Y;
            hold_q       <= HOLD_INIT;
            vsync_prev_q <= 1'b0;
            p1_prev_q    <= 4'd0;
            p2_prev_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hold_q       <= hold_d;
            vsync_prev_q <= bus.vsync_in;
            p1_prev_q    <= bus.player_1_score;
            p2_prev_q    <= bus.player_2_score;
        end
    end

    assign bus.xpos_out  = x_q;
    assign bus.ypos_out  = y_q;
    assign bus.state_out = state_q;
endmodule

// File: tb/tb_player2_ai_ctl.sv
// tb_player2_ai_ctl: directed stimulus against a frame-level behavioural model,
// checked every cycle, plus hand-computed literal checkpoints.
module tb_player2_ai_ctl;
    logic clk = 1'b0;
    logic rst_n;
    player2_ai_ctl_if bus ();

    player2_ai_ctl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int m_x, m_y, m_state, m_hold, m_vs, m_s1, m_s2;
    int bx, by, s1, s2;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic int toward(input int p, input int t);
        if (t - p > 4) return p + 4;
        if (p - t > 4) return p - 4;
        return t;
    endfunction

    task automatic model_reset();
        m_x = 900; m_y = 384; m_state = 0; m_hold = 60;
        m_vs = 0; m_s1 = 0; m_s2 = 0;
    endtask

    task automatic model_clock(input int vs);
        bit goal, tick;
        goal = (s1 != m_s1) || (s2 != m_s2);
        tick = (vs != 0) && (m_vs == 0);
        m_vs = vs; m_s1 = s1; m_s2 = s2;
        if (goal) begin
            m_x = 900; m_y = 384; m_state = 0; m_hold = 60;
        end else if (tick) begin
            if (m_state == 0 && m_hold > 0) m_hold--;
            else begin
                m_state = (bx >= 512) ? 2 : 1;
                m_x = toward(m_x, clampi((m_state == 2) ? bx : 900, 532, 980));
                m_y = toward(m_y, clampi(by, 40, 728));
            end
        end
    endtask

    task automatic cycle(input int vs);
        @(negedge clk);
        #1;
        bus.vsync_in       = vs[0];
        bus.xpos_ball      = 12'(bx);
        bus.ypos_ball      = 12'(by);
        bus.player_1_score = 4'(s1);
        bus.player_2_score = 4'(s2);
        if (rst_n) model_clock(vs);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1); cycle(0); cycle(0);
        end
    endtask

    task automatic pin(input string name, input int x, input int y, input int st);
        check({name, ".x"}, int'(bus.xpos_out), x);
        check({name, ".y"}, int'(bus.ypos_out), y);
        check({name, ".state"}, int'(bus.state_out), st);
    endtask

    always @(negedge clk) begin
        check("model.x", int'(bus.xpos_out), m_x);
        check("model.y", int'(bus.ypos_out), m_y);
        check("model.state", int'(bus.state_out), m_state);
    end

    initial begin
        rst_n = 1'b0;
        bx = 700; by = 100; s1 = 0; s2 = 0;
        bus.vsync_in = 1'b0;
        bus.xpos_ball = 12'd700; bus.ypos_ball = 12'd100;
        bus.player_1_score = 4'd0; bus.player_2_score = 4'd0;
        model_reset();
        cycle(0); cycle(0);
        pin("reset", 900, 384, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        cycle(0);
        ticks(60);
        pin("hold60", 900, 384, 0);
        ticks(1);
        pin("tick61", 896, 380, 2);
        ticks(49);
        pin("track49", 700, 184, 2);
        ticks(30);
        pin("track_settle", 700, 100, 2);

        by = 300;
        ticks(50);
        pin("pos700_300", 700, 300, 2);
        bx = 200; by = 10;
        ticks(1);
        pin("guard1", 704, 296, 1);
        ticks(49);
        check("guard50.x", int'(bus.xpos_out), 900);
        ticks(15);
        pin("guard65", 900, 40, 1);
        ticks(5);
        pin("guard_stable", 900, 40, 1);

        bx = 703; by = 40;
        ticks(60);
        pin("pos703", 703, 40, 2);
        bx = 1010; by = 760;
        ticks(69);
        check("clamp69.x", int'(bus.xpos_out), 979);
        ticks(1);
        check("clamp70.x", int'(bus.xpos_out), 980);
        ticks(110);
        pin("clamp_final", 980, 728, 2);

        bx = 600; by = 500;
        ticks(10);
        s1 = 1;
        cycle(1); cycle(0); cycle(0);
        pin("goal", 900, 384, 0);
        ticks(60);
        pin("goal_hold", 900, 384, 0);
        ticks(1);
        pin("goal_resume", 896, 388, 2);

        repeat (100) cycle(1);
        cycle(0); cycle(0);
        pin("vsync_long", 892, 392, 2);

        @(negedge clk);
        #3 rst_n = 1'b0;
        model_reset();
        #1 pin("async_rst", 900, 384, 0);
        cycle(0); cycle(0);
        @(negedge clk); #1 rst_n = 1'b1;
        cycle(0);
        ticks(3);
        pin("post_rst", 900, 384, 0);
        cycle(0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
